// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, optionally
// repeating it, and counts overlapping "101" runs in the transmitted stream.
module pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  input  logic             loop,
  input  logic             stop,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       hits
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_len;
  logic [3:0]       r_cnt;
  logic             r_loop;
  logic             r_stop_pend;
  logic [1:0]       r_hist;
  logic             r_x;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_hits;

  logic [3:0]       w_len_eff;
  logic             w_more;
  logic             w_stop_eff;
  logic             w_reload;
  logic [WIDTH-1:0] w_src;
  logic             w_bit;
  logic             w_hit;

  assign w_len_eff  = (len == 4'd0 || len > 4'(WIDTH)) ? 4'(WIDTH) : len;
  // r_cnt holds the bits still to send after the one currently on x.
  assign w_more     = (r_cnt != 4'd0);
  assign w_stop_eff = r_stop_pend | stop;
  assign w_reload   = !w_more && r_loop && !w_stop_eff;
  assign w_src      = w_more ? r_shift : r_pat;
  assign w_bit      = w_src[WIDTH-1];
  assign w_hit      = (r_hist == 2'b10) && w_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_shift     <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_loop      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_hist      <= 2'b00;
      r_x         <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hits      <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pat       <= data;
            r_shift     <= data << 1;
            r_len       <= w_len_eff;
            r_cnt       <= w_len_eff - 4'd1;
            r_loop      <= loop;
            r_stop_pend <= 1'b0;
            r_hist      <= {1'b0, data[WIDTH-1]};
            r_hits      <= 8'd0;
            r_x         <= data[WIDTH-1];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_more || w_reload) begin
            r_x         <= w_bit;
            r_shift     <= w_src << 1;
            r_cnt       <= w_more ? r_cnt - 4'd1 : r_len - 4'd1;
            r_hist      <= {r_hist[0], w_bit};
            r_stop_pend <= w_stop_eff;
            if (w_hit && r_hits != 8'hFF)
              r_hits <= r_hits + 8'd1;
          end else begin
            r_x         <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_stop_pend <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x     = r_x;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  assign hits  = r_hits;

endmodule
